// File: rtl/snake_pkg.sv
// Shared definitions for the snake board RAM controller: default
// geometry, board cell codes and the controller FSM state encoding.
package snake_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 4;

    // Board cell codes stored in the RAM
    localparam logic [3:0] CELL_EMPTY = 4'h0;
    localparam logic [3:0] CELL_SNAKE = 4'h1;
    localparam logic [3:0] CELL_HEAD  = 4'h2;
    localparam logic [3:0] CELL_FOOD  = 4'h3;

    // Transaction owner tags
    localparam logic OWN_DISP = 1'b0;
    localparam logic OWN_GAME = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_CLR  = 3'd4
    } state_e;

endpackage

// File: rtl/snake_ram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the display, bit 1 the game.
// The pointer names the favoured requester on a tie and flips to the
// other side whenever a grant is taken (adv_i).
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic r_ptr;

    // Grant selection: a lone requester always wins, a tie follows the pointer
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = r_ptr ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer update: after a grant the other requester is favoured
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= 1'b0;
        end else if (adv_i) begin
            r_ptr <= gnt_o[0];
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/snake_ram_ctrl.sv
// Board RAM sequencer/arbiter. Shares a single-port 256x4 RAM between the
// display scanner (reads) and the game logic (reads/writes), and runs a
// full-board clear sweep on request. All RAM pins decode from registers.
module snake_ram_ctrl
    import snake_pkg::*;
#(
    parameter int            AW      = AW_DEF,
    parameter int            DW      = DW_DEF,
    parameter logic [DW-1:0] CLR_VAL = DW'(CELL_EMPTY)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic          disp_gnt_o,
    output logic          disp_vld_o,
    output logic [DW-1:0] disp_data_o,
    input  logic          game_req_i,
    input  logic          game_we_i,
    input  logic [AW-1:0] game_addr_i,
    input  logic [DW-1:0] game_wdata_i,
    output logic          game_gnt_o,
    output logic          game_vld_o,
    output logic [DW-1:0] game_rdata_o,
    input  logic          clr_start_i,
    output logic          clr_busy_o,
    output logic          ram_wr_en_o,
    output logic          ram_rd_en_o,
    output logic [AW-1:0] ram_addr_o,
    inout  wire  [DW-1:0] ram_data_io
);

    state_e        r_state;
    state_e        w_next;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_owner;
    logic [AW-1:0] r_clr_cnt;
    logic          r_disp_vld;
    logic          r_game_vld;
    logic [DW-1:0] r_disp_data;
    logic [DW-1:0] r_game_rdata;

    logic [1:0]    w_arb_gnt;
    logic          w_idle_ok;
    logic          w_gnt_any;
    logic          w_sel_game;
    logic          w_sel_we;
    logic          w_drive;

    // Grants only in IDLE, never while in reset, and a clear start wins
    assign w_idle_ok  = (r_state == ST_IDLE) && rst_ni && !clr_start_i;
    assign w_gnt_any  = w_idle_ok && (w_arb_gnt != 2'b00);
    assign w_sel_game = w_arb_gnt[1];
    assign w_sel_we   = w_sel_game && game_we_i;

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  ({game_req_i, disp_req_i}),
        .adv_i  (w_gnt_any),
        .gnt_o  (w_arb_gnt)
    );

    // Next-state selection for the transaction/clear sequencer
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clr_start_i) begin
                    w_next = ST_CLR;
                end else if (w_gnt_any) begin
                    w_next = w_sel_we ? ST_WR : ST_RD1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR:   w_next = ST_IDLE;
            ST_RD1:  w_next = ST_RD2;
            ST_RD2:  w_next = ST_IDLE;
            ST_CLR: begin
                if (r_clr_cnt == {AW{1'b1}}) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_CLR;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, clear counter, completion pulses and read-data capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= {AW{1'b0}};
            r_wdata      <= {DW{1'b0}};
            r_owner      <= OWN_DISP;
            r_clr_cnt    <= {AW{1'b0}};
            r_disp_vld   <= 1'b0;
            r_game_vld   <= 1'b0;
            r_disp_data  <= {DW{1'b0}};
            r_game_rdata <= {DW{1'b0}};
        end else begin
            if (w_gnt_any) begin
                r_addr  <= w_sel_game ? game_addr_i : disp_addr_i;
                r_wdata <= w_sel_game ? game_wdata_i : r_wdata;
                r_owner <= w_sel_game ? OWN_GAME : OWN_DISP;
            end
            // Counter runs through every cell and wraps back to 0 on exit
            if (r_state == ST_CLR) begin
                r_clr_cnt <= r_clr_cnt + {{(AW-1){1'b0}}, 1'b1};
            end
            r_disp_vld <= (r_state == ST_RD2) && (r_owner == OWN_DISP);
            r_game_vld <= ((r_state == ST_RD2) || (r_state == ST_WR)) && (r_owner == OWN_GAME);
            if (r_state == ST_RD2) begin
                if (r_owner == OWN_GAME) begin
                    r_game_rdata <= ram_data_io;
                end else begin
                    r_disp_data <= ram_data_io;
                end
            end
        end
    end

    // RAM pin decode; the bus is driven only in write states, never while reading
    assign ram_wr_en_o = (r_state == ST_WR) || (r_state == ST_CLR);
    assign ram_rd_en_o = (r_state == ST_RD1) || (r_state == ST_RD2);
    assign ram_addr_o  = (r_state == ST_CLR) ? r_clr_cnt : r_addr;
    assign w_drive     = ram_wr_en_o;
    assign ram_data_io = w_drive ? ((r_state == ST_CLR) ? CLR_VAL : r_wdata) : {DW{1'bz}};

    assign clr_busy_o   = (r_state == ST_CLR);
    assign disp_gnt_o   = w_idle_ok && w_arb_gnt[0];
    assign game_gnt_o   = w_idle_ok && w_arb_gnt[1];
    assign disp_vld_o   = r_disp_vld;
    assign game_vld_o   = r_game_vld;
    assign disp_data_o  = r_disp_data;
    assign game_rdata_o = r_game_rdata;

endmodule

// File: tb/tb_snake_ram_ctrl.sv
// Bench for snake_ram_ctrl: behavioural board RAM, an acceptance process
// that pushes expected responses into per-requester queues when a request
// is granted, and a monitor that pops and compares on every vld pulse.
module tb_snake_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       disp_req = 1'b0;
    logic [7:0] disp_addr = 8'h00;
    logic       disp_gnt, disp_vld;
    logic [3:0] disp_data;
    logic       game_req = 1'b0;
    logic       game_we = 1'b0;
    logic [7:0] game_addr = 8'h00;
    logic [3:0] game_wdata = 4'h0;
    logic       game_gnt, game_vld;
    logic [3:0] game_rdata;
    logic       clr_start = 1'b0;
    logic       clr_busy, ram_wr_en, ram_rd_en;
    logic [7:0] ram_addr;
    wire  [3:0] ram_data;

    pullup pu0 (ram_data[0]);
    pullup pu1 (ram_data[1]);
    pullup pu2 (ram_data[2]);
    pullup pu3 (ram_data[3]);

    always #5 clk = ~clk;

    snake_ram_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .disp_req_i   (disp_req),
        .disp_addr_i  (disp_addr),
        .disp_gnt_o   (disp_gnt),
        .disp_vld_o   (disp_vld),
        .disp_data_o  (disp_data),
        .game_req_i   (game_req),
        .game_we_i    (game_we),
        .game_addr_i  (game_addr),
        .game_wdata_i (game_wdata),
        .game_gnt_o   (game_gnt),
        .game_vld_o   (game_vld),
        .game_rdata_o (game_rdata),
        .clr_start_i  (clr_start),
        .clr_busy_o   (clr_busy),
        .ram_wr_en_o  (ram_wr_en),
        .ram_rd_en_o  (ram_rd_en),
        .ram_addr_o   (ram_addr),
        .ram_data_io  (ram_data)
    );

    // Board RAM: registers the cell on a read cycle, drives it in the second read cycle
    logic [3:0] mem [256];
    logic [3:0] ram_q = 4'h0;
    logic       ram_rd_d = 1'b0;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_data;
        if (ram_rd_en) ram_q <= mem[ram_addr];
        ram_rd_d <= ram_rd_en;
    end
    assign ram_data = (ram_rd_en && ram_rd_d) ? ram_q : 4'bzzzz;

    typedef struct packed {
        logic        is_rd;
        logic [3:0]  data;
        logic [31:0] due;
    } exp_t;

    exp_t       gq[$];
    exp_t       dq[$];
    logic [3:0] ref_mem [256];
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;
    logic       exp_ptr = 1'b0;
    logic       was_busy = 1'b0;
    int         busy_len = 0;
    int         last_busy_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance: reference model of the board, grant rules, clear bookkeeping
    always @(negedge clk) begin : acc
        if (!rst_n) begin
            exp_ptr  = 1'b0;
            was_busy = 1'b0;
            busy_len = 0;
        end else begin
            chk("one_gnt", 32'(disp_gnt & game_gnt), 32'd0);
            if (clr_busy) chk("no_gnt_while_busy", 32'(disp_gnt | game_gnt), 32'd0);
            if (disp_gnt || game_gnt) begin
                if (disp_req && game_req) chk("rr_order_game", 32'(game_gnt), 32'(exp_ptr));
                exp_ptr = disp_gnt;
                if (disp_gnt) begin
                    dq.push_back('{1'b1, ref_mem[disp_addr], 32'(cyc + 3)});
                end else if (game_we) begin
                    ref_mem[game_addr] = game_wdata;
                    gq.push_back('{1'b0, game_wdata, 32'(cyc + 2)});
                end else begin
                    gq.push_back('{1'b1, ref_mem[game_addr], 32'(cyc + 3)});
                end
            end
            if (clr_busy && !was_busy) begin
                for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
                busy_len = 0;
            end
            if (clr_busy) busy_len++;
            if (!clr_busy && was_busy) begin
                chk("clr_busy_len", 32'(busy_len), 32'd256);
                last_busy_cyc = cyc - 1;
            end
            was_busy = clr_busy;
        end
    end

    // Monitor: reset state, bus invariants, and scoreboard pops on vld
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            chk("reset_outputs", 32'({disp_gnt, disp_vld, disp_data, game_gnt, game_vld, game_rdata,
                                      clr_busy, ram_wr_en, ram_rd_en, ram_addr}), 32'd0);
            chk("reset_bus_z", 32'(ram_data), 32'hF);
            gq.delete();
            dq.delete();
        end else begin
            chk("no_wr_rd_overlap", 32'(ram_wr_en & ram_rd_en), 32'd0);
            if (!ram_wr_en && !ram_rd_en) chk("bus_released", 32'(ram_data), 32'hF);
            if (game_vld) begin
                if (gq.size() == 0) chk("game_vld_unexpected", 32'd1, 32'd0);
                else begin
                    e = gq.pop_front();
                    chk("game_vld_cycle", 32'(cyc), e.due);
                    if (e.is_rd) chk("game_rdata", 32'(game_rdata), 32'(e.data));
                end
            end else if (gq.size() != 0 && gq[0].due < 32'(cyc)) begin
                chk("game_vld_missing", 32'(cyc), gq[0].due);
                void'(gq.pop_front());
            end
            if (disp_vld) begin
                if (dq.size() == 0) chk("disp_vld_unexpected", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    chk("disp_vld_cycle", 32'(cyc), e.due);
                    chk("disp_data", 32'(disp_data), 32'(e.data));
                end
            end else if (dq.size() != 0 && dq[0].due < 32'(cyc)) begin
                chk("disp_vld_missing", 32'(cyc), dq[0].due);
                void'(dq.pop_front());
            end
        end
    end

    task automatic game_op(input logic we, input logic [7:0] a, input logic [3:0] d, output int g);
        g = -1;
        @(posedge clk); #1;
        game_req = 1'b1; game_we = we; game_addr = a; game_wdata = d;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (game_gnt) begin g = cyc; break; end
        end
        if (g < 0) chk("game_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        game_req = 1'b0;
    endtask

    task automatic disp_rd(input logic [7:0] a, output int g);
        g = -1;
        @(posedge clk); #1;
        disp_req = 1'b1; disp_addr = a;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (disp_gnt) begin g = cyc; break; end
        end
        if (g < 0) chk("disp_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        disp_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, g2, sc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Clear sweep with marked corner cells, a mid-sweep start, and a pending request
        game_op(1'b1, 8'h00, 4'hF, g);
        game_op(1'b1, 8'hFF, 4'hF, g);
        repeat (3) @(posedge clk);
        #1 clr_start = 1'b1;
        sc = cyc;
        @(posedge clk); #1 clr_start = 1'b0;
        @(negedge clk);
        chk("clr_busy_next_cycle", 32'(clr_busy), 32'd1);
        chk("clr_busy_cycle", 32'(cyc), 32'(sc + 1));
        repeat (3) @(posedge clk);
        #1 clr_start = 1'b1;
        @(posedge clk); #1 clr_start = 1'b0;
        game_op(1'b0, 8'h00, 4'h0, g);
        chk("gnt_after_clr", 32'(g), 32'(last_busy_cyc + 1));
        disp_rd(8'hFF, g);
        repeat (5) @(negedge clk);
        chk("clr_not_requeued", 32'(clr_busy), 32'd0);

        // Directed write then read
        game_op(1'b1, 8'h12, 4'h5, g);
        game_op(1'b0, 8'h12, 4'h0, g);
        repeat (4) @(posedge clk);

        // Both requesters pressing continuously
        fork
            begin
                for (int i = 0; i < 6; i++) game_op(1'(i % 2), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), g);
            end
            begin
                for (int j = 0; j < 6; j++) disp_rd(8'($urandom_range(0, 255)), g2);
            end
        join
        repeat (4) @(posedge clk);

        // Randomized mixed traffic over a small address window
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    game_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), g);
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    disp_rd(8'($urandom_range(0, 7)), g2);
                end
            end
        join
        repeat (4) @(posedge clk);

        // Reset asserted during the second read cycle drops the transaction
        @(posedge clk); #1;
        game_req = 1'b1; game_we = 1'b0; game_addr = 8'h12;
        g = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (game_gnt) begin g = cyc; break; end
        end
        if (g < 0) chk("rst_test_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1 game_req = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rd2_rd_en_low", 32'(ram_rd_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        game_op(1'b1, 8'h40, 4'hA, g);
        game_op(1'b0, 8'h40, 4'h0, g);
        repeat (4) @(posedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        fork
            game_op(1'b0, 8'h40, 4'h0, g);
            disp_rd(8'h40, g2);
        join
        chk("rr_display_first_after_reset", 32'(g2 < g), 32'd1);
        repeat (6) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
